// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory write port: packs big-endian bytes into
// 32-bit words written from BASE_ADDR upward. Define IMEM_LOADER_CHECKSUM_EN for a trailing checksum.
module imem_loader #(
  parameter int BASE_ADDR   = 40,
  parameter int DEPTH_WORDS = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] COLLECT = 3'd1;
  localparam logic [2:0] WRITE   = 3'd2;
  localparam logic [2:0] CHECK   = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]  state;
  logic [1:0]  byte_cnt;
  logic [7:0]  word_cnt;
  logic [7:0]  word_total;
  logic [31:0] shift;
  logic        xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] acc;
  logic [31:0] chk;
`endif

  // True when the requested load would run past the end of the instruction memory.
  function automatic logic range_bad(input logic [7:0] n);
    logic [31:0] last_word;
    last_word = 32'(BASE_ADDR / 4) + {24'd0, n};
    return last_word > 32'(DEPTH_WORDS);
  endfunction

  assign byte_ready = (state == COLLECT) || (state == CHECK);
  assign mem_we     = (state == WRITE);
  assign busy       = (state == COLLECT) || (state == WRITE) || (state == CHECK);
  assign done       = (state == DONE);
  assign xfer       = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      word_cnt   <= 8'd0;
      word_total <= 8'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            word_total <= word_count;
            word_cnt   <= 8'd0;
            byte_cnt   <= 2'd0;
            err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc        <= 32'd0;
`endif
            if (range_bad(word_count)) begin
              err   <= 1'b1;
              state <= DONE;
            end else if (word_count == 8'd0) begin
              state <= DONE;
            end else begin
              mem_addr <= 32'(BASE_ADDR);
              state    <= COLLECT;
            end
          end
        end
        COLLECT: begin
          // mem_wdata is only updated once the word is complete, so it stays stable between writes.
          if (xfer) begin
            shift    <= {shift[23:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_wdata <= {shift[23:0], byte_data};
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          mem_addr <= mem_addr + 32'd4;
          word_cnt <= word_cnt + 8'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          acc      <= acc + mem_wdata;
`endif
          if (word_cnt == word_total - 8'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= CHECK;
`else
            state <= DONE;
`endif
          end else begin
            state <= COLLECT;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          // Checksum bytes are compared against the running sum and never reach memory.
          if (xfer) begin
            chk      <= {chk[23:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if ({chk[23:0], byte_data} != acc) err <= 1'b1;
              state <= DONE;
            end
          end
        end
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed loads push expected writes and done/err results;
// a negedge monitor pops and compares them as the DUT presents them.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  word_count, byte_data;
  logic        byte_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;

  always #5 clk = ~clk;

  imem_loader #(.BASE_ADDR(40), .DEPTH_WORDS(250)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          done_seen = 0;
  int          done_base = 0;
  logic [63:0] exp_wr[$];
  logic        exp_err[$];
  logic [63:0] e;
  logic [31:0] addr_model, sum_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every write and every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", mem_addr, e[63:32]);
        check("wr_data", mem_wdata, e[31:0]);
        check("ready_in_write", {31'd0, byte_ready}, 32'd0);
        check("busy_in_write", {31'd0, busy}, 32'd1);
      end
    end
    if (done === 1'b1) begin
      if (exp_err.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1, required 0");
      end else begin
        check("done_err", {31'd0, err}, {31'd0, exp_err.pop_front()});
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
      done_seen++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) check("byte_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    exp_wr.push_back({addr_model, w});
    addr_model += 32'd4;
    sum_model  += w;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send_chk(input logic [31:0] c);
`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int i = 0; i < 4; i++) send_byte(c[31-8*i -: 8]);
`else
    if (c === 32'hxxxx_xxxx) $display("note: checksum disabled");
`endif
  endtask

  task automatic do_start(input logic [7:0] n, input bit expect_collect);
    addr_model = 32'd40;
    sum_model  = 32'd0;
    done_base  = done_seen;
    start      = 1'b1;
    word_count = n;
    @(posedge clk); #1;
    start      = 1'b0;
    word_count = 8'hEE;
    if (expect_collect) check("ready_latency", {31'd0, byte_ready}, 32'd1);
  endtask

  task automatic wait_done(input logic exp_e);
    int t;
    t = 0;
    exp_err.push_back(exp_e);
    while (done_seen == done_base && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) check("done_timeout", 32'd0, 32'd1);
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0; word_count = 8'd0;
    addr_model = 32'd40; sum_model = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // single word, back-to-back bytes
    do_start(8'd1, 1'b1);
    send_word(32'h2008_0005, 1'b0);
    send_chk(sum_model);
    wait_done(1'b0);

    // three words with gaps between bytes
    do_start(8'd3, 1'b1);
    send_word(32'h3C01_1001, 1'b1);
    send_word(32'h8C22_0004, 1'b1);
    send_word(32'hAC23_0008, 1'b1);
    send_chk(sum_model);
    wait_done(1'b0);

    // range error, sticky err, then zero count clears it
    do_start(8'd241, 1'b0);
    wait_done(1'b1);
    @(posedge clk); #1;
    check("err_sticky", {31'd0, err}, 32'd1);
    do_start(8'd0, 1'b0);
    wait_done(1'b0);
    check("err_cleared", {31'd0, err}, 32'd0);

    // start pulsed while collecting is ignored
    do_start(8'd2, 1'b1);
    start = 1'b1; word_count = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_ignore_start", {31'd0, busy}, 32'd1);
    send_word(32'hDEAD_BEEF, 1'b0);
    send_word(32'h0123_4567, 1'b0);
    send_chk(sum_model);
    wait_done(1'b0);

    // reset after two bytes of word 2
    do_start(8'd3, 1'b1);
    send_word(32'h1122_3344, 1'b0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_wdata", mem_wdata, 32'd0);
    do_start(8'd1, 1'b1);
    send_word(32'h0102_0304, 1'b0);
    send_chk(sum_model);
    wait_done(1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_start(8'd2, 1'b1);
    send_word(32'h0000_0001, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0);
    send_chk(32'h0000_0000);
    wait_done(1'b0);
    do_start(8'd2, 1'b1);
    send_word(32'h0000_0001, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0);
    send_chk(32'h0000_0001);
    wait_done(1'b1);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("pending_writes", 32'(exp_wr.size()), 32'd0);
    check("pending_dones", 32'(exp_err.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory; the instruction memory itself is the read-only, word-indexed side.
- Receives a byte stream over a valid/ready handshake and packs each group of 4 bytes into one big-endian 32-bit MIPS instruction word.
- Issues one-cycle word writes to the instruction memory write port at consecutive word-aligned byte addresses, starting at BASE_ADDR.
- Holds busy high for the whole load so the CPU core can be stalled.

Parameters:
- BASE_ADDR, 40, byte address of the first loaded word (word index 10); must be a multiple of 4.
- DEPTH_WORDS, 250, number of 32-bit words in the instruction memory.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; ignored while busy=1.
- word_count  in  8  number of words to load; sampled only in the cycle start is accepted.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  stream byte; the first byte of each word is bits 31:24.
- byte_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  one-cycle write strobe to the instruction memory.
- mem_addr  out  32  byte address of the write; always word-aligned.
- mem_wdata  out  32  assembled instruction word.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse marking the end of a load.
- err  out  1  sticky error flag; cleared only by the next accepted start.

Behaviour:
- Reset: state IDLE. byte_ready, mem_we, busy, done and err are all 0. mem_addr = 0, mem_wdata = 0, byte counter = 0, word counter = 0.
- Reset mid-load: returns to IDLE next cycle and discards any partial word. Words already written stay in memory.
- IDLE:
  - start=1 is accepted. word_count is latched and err is cleared.
  - Range error: if BASE_ADDR/4 + word_count > DEPTH_WORDS, set err=1 and go to DONE with no writes.
  - If word_count = 0, go to DONE with no writes.
  - Otherwise go to COLLECT. mem_addr ← BASE_ADDR, byte counter ← 0.
- COLLECT:
  - byte_ready=1. A byte is transferred only when byte_valid && byte_ready.
  - Each transferred byte shifts in: wdata ← {wdata[23:0], byte_data}.
  - byte_valid=0 stalls indefinitely with no timeout.
  - When the 4th byte transfers, go to WRITE.
- WRITE (one cycle):
  - byte_ready=0, mem_we=1, mem_addr and mem_wdata hold the current word.
  - Next cycle: mem_addr += 4 and the word counter increments.
  - If this was the last word, go to CHECK when CHECKSUM_EN is defined, otherwise to DONE. If not the last word, return to COLLECT.
- DONE (one cycle): done=1, busy=0, then go to IDLE.
- busy: 1 in COLLECT, WRITE and CHECK; 0 in IDLE and DONE.
- Latency:
  - start accepted in cycle N → byte_ready=1 in cycle N+1.
  - 4th byte of a word accepted in cycle M → mem_we=1 in M+1 → byte_ready=1 again in M+2.
  - Sustained throughput: 1 word per 5 cycles.
- Simultaneous events:
  - start while busy=1: ignored, no effect.
  - byte_valid in IDLE, WRITE or DONE: no transfer, since byte_ready=0.
- Outside WRITE, mem_we=0; mem_addr and mem_wdata hold their last values.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A 32-bit accumulator is cleared on accepted start and adds each written word modulo 2^32.
  - After the last WRITE, state CHECK accepts 4 more bytes (big-endian) as the expected checksum; these bytes are not written to memory.
  - On the 4th checksum byte: if the checksum ≠ accumulator, set err=1; then go to DONE.
  - For word_count=0 or a range error, CHECK is skipped.
- Not defined: no CHECK state and no accumulator; err reports range errors only.

Test Plan:
- Single word: start with word_count=1, stream bytes 0x20,0x08,0x00,0x05 back-to-back → exactly one mem_we pulse with mem_addr=40, mem_wdata=0x20080005, then done pulse; busy=0 afterwards.
- Gapped multi-word: word_count=3 with byte_valid deasserted on alternate cycles → writes to addresses 40, 44, 48 in order, each byte_ready low in its WRITE cycle; done after the third write.
- Range error and zero count:
  - word_count=241 with BASE_ADDR=40 → err=1, no mem_we, done pulse.
  - word_count=0 → done pulse with no writes and err=0.
- Reset mid-word: after 2 bytes of word 2, assert reset for 1 cycle → IDLE and all outputs 0. A new load starts again at address 40 with correct packing, and the stale partial word is never written.
- Start while busy: start pulsed during COLLECT → ignored; the write sequence and word count are unchanged.
- Checksum (IMEM_LOADER_CHECKSUM_EN):
  - Words 0x00000001 and 0xFFFFFFFF, then checksum bytes 00 00 00 00 → err=0.
  - Same words with checksum 00 00 00 01 → err=1.
  - In both cases, exactly 2 writes and a done pulse.
